// File: rtl/fpu_op_sequencer_pkg.sv
// Shared types and helpers for the FPU operation sequencer: request encoding,
// sequencer states, FPU flag layout and opcode translation.
package fpu_op_sequencer_pkg;

    typedef logic [31:0] op_t;
    typedef logic [1:0]  rmode_t;

    localparam op_t OP_ADD = 32'h0000_0080;
    localparam op_t OP_SUB = 32'h0000_0081;
    localparam op_t OP_MUL = 32'h0000_0082;
    localparam op_t OP_DIV = 32'h0000_0083;

    typedef enum logic [1:0] {
        RM_NEAREST = 2'd0,
        RM_ZERO    = 2'd1,
        RM_UP      = 2'd2,
        RM_DOWN    = 2'd3
    } rmode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } seq_state_t;

    // Flag vector layout: {snan,qnan,zero,inf,divzero,underflow,overflow,inexact}
    localparam int FPU_FLAGS_W    = 8;
    localparam int FLAG_SNAN      = 7;
    localparam int FLAG_QNAN      = 6;
    localparam int FLAG_ZERO      = 5;
    localparam int FLAG_INF       = 4;
    localparam int FLAG_DIVZERO   = 3;
    localparam int FLAG_UNDERFLOW = 2;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_INEXACT   = 0;

    // One queued request; op sits in the MSBs so a flat {op,rmode,opa,opb}
    // concatenation maps directly onto this struct.
    typedef struct packed {
        op_t         op;
        rmode_t      rmode;
        logic [31:0] opa;
        logic [31:0] opb;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    // Only the four arithmetic opcodes 0x80..0x83 are accepted.
    function automatic logic op_legal(input op_t op);
        return (op[31:8] == 24'h0) && op[7] && (op[6:2] == 5'h0);
    endfunction

    function automatic logic [2:0] op_to_fpu(input op_t op);
        return {1'b0, op[1:0]};
    endfunction

endpackage

// File: rtl/fpu_op_sequencer_fifo.sv
// Request buffer: power-of-two circular FIFO with one extra pointer bit to
// tell full from empty. Read data is the current head, valid while not empty.
module fpu_req_fifo #(
    parameter int WIDTH = 98,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // Pointer advance; pointers wrap naturally through the extra MSB.
    always_comb begin
        wptr_d = do_push ? (wptr_q + PTR_ONE) : wptr_q;
        rptr_d = do_pop  ? (rptr_q + PTR_ONE) : rptr_q;
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage; contents need no reset since empty pointers mask them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Buffers FPU operation requests and issues them one at a time to the FPU,
// returning result, flags and an error bit over a valid/ready response port.
//
//   state | meaning
//   IDLE  | waiting for a queued request; pops and decodes the head
//   ISSUE | fpu_start_o high for one cycle, timeout counter cleared
//   WAIT  | operands held, waiting for fpu_ready_i or timeout
//   RESP  | response presented until rsp_ready
module fpu_op_sequencer
    import fpu_op_sequencer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_op,
    input  logic [1:0]  req_rmode,
    input  logic [31:0] req_opa,
    input  logic [31:0] req_opb,
    output logic        fpu_start_o,
    output logic [2:0]  fpu_op_o,
    output logic [1:0]  fpu_rmode_o,
    output logic [31:0] fpu_opa_o,
    output logic [31:0] fpu_opb_o,
    input  logic        fpu_ready_i,
    input  logic [31:0] fpu_result_i,
    input  logic [7:0]  fpu_flags_i,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [7:0]  rsp_flags,
    output logic        rsp_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    seq_state_t              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2:0]              op_q, op_d;
    logic [1:0]              rmode_q, rmode_d;
    logic [31:0]             opa_q, opa_d;
    logic [31:0]             opb_q, opb_d;
    logic [31:0]             res_q, res_d;
    logic [FPU_FLAGS_W-1:0]  flags_q, flags_d;
    logic                    err_q, err_d;

    logic [REQ_W-1:0]        wr_data;
    logic [REQ_W-1:0]        head_raw;
    req_t                    head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;

    assign wr_data = {req_op, req_rmode, req_opa, req_opb};
    assign head    = req_t'(head_raw);

    fpu_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (req_valid),
        .wdata_i (wr_data),
        .pop_i   (pop),
        .rdata_o (head_raw),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign req_ready   = !fifo_full;
    assign fpu_start_o = (state_q == ISSUE);
    assign fpu_op_o    = op_q;
    assign fpu_rmode_o = rmode_q;
    assign fpu_opa_o   = opa_q;
    assign fpu_opb_o   = opb_q;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_result  = res_q;
    assign rsp_flags   = flags_q;
    assign rsp_err     = err_q;

    // Next-state, FIFO pop, operand load, timeout count and response capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rmode_d = rmode_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        flags_d = flags_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (op_legal(head.op)) begin
                        op_d    = op_to_fpu(head.op);
                        rmode_d = head.rmode;
                        opa_d   = head.opa;
                        opb_d   = head.opb;
                        state_d = ISSUE;
                    end else begin
                        res_d   = '0;
                        flags_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (fpu_ready_i) begin
                    res_d   = fpu_result_i;
                    flags_d = fpu_flags_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_d   = '0;
                    flags_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, FPU operand and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rmode_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rmode_q <= rmode_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

endmodule
